mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the MA stage and of instruction fetch.
- Takes MA's ram_we/ram_re/ram_addr/ram_width/ram_wdata word-level requests and IF word fetches.
- Serializes each request into byte transfers on the 8-bit synchronous RAM/IO bus.
- Returns assembled, sign/zero-extended data with a busy/done handshake.
- Arbitrates the single memory port between MA and IF.

Parameters:
- ADDR_W, 32, width of byte address to memory bus

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- rdy  in  1  global run enable; 0 freezes all state
- ram_we  in  1  MA store request (level, held until done)
- ram_re  in  1  MA load request (level, held until done)
- ram_addr  in  32  MA byte address
- ram_width  in  3  [1:0] 00=byte 01=half 10=word; [2]=1 zero-extend load
- ram_wdata  in  32  MA store data, little-endian, low bytes used
- ram_rdata  out  32  MA load result, valid in DONE cycle
- ram_busy  out  1  MA stall: high while MA request is pending and not done
- if_re  in  1  fetch request (level, held until done)
- if_addr  in  32  fetch address (word access)
- if_rdata  out  32  fetched instruction, valid in DONE cycle
- if_busy  out  1  fetch stall
- mem_din  in  8  byte from memory, valid one cycle after mem_a issued
- mem_dout  out  8  byte to memory
- mem_a  out  32  byte address to memory
- mem_wr  out  1  1 = write mem_dout to mem_a this cycle

Behaviour:
- Reset (rst=0, async): state IDLE; mem_wr=0, mem_a=0, mem_dout=0, ram_rdata=0, if_rdata=0, byte counter=0, owner=none.
- ram_busy, if_busy are combinational; both 0 during reset.
- States: IDLE, XFER, WAIT, DONE.
- IDLE:
  - ram_busy = ram_re|ram_we in the same cycle; if_busy = if_re.
  - On the edge, latch owner (MA has priority over IF), address, N (1/2/4; IF always 4), write data, extend flag, then go to XFER.
  - ram_we and ram_re both high: treated as store.
- XFER, cycle i (i=0..N-1):
  - mem_a = base+i; no alignment requirement; address wraps modulo 2^32.
  - Store: mem_wr=1, mem_dout = wdata byte i.
  - Load: mem_wr=0; byte i-1 captured from mem_din into result[8(i-1)+:8] at the edge ending this cycle.
  - After cycle N-1: store -> DONE, load -> WAIT.
- WAIT: mem_wr=0; captures byte N-1 -> DONE.
- DONE, exactly one cycle:
  - Owner's busy=0; result valid on ram_rdata/if_rdata (held until next load completes).
  - Load extension: width 00 sign-extends bit7 (zero if [2]=1); width 01 sign-extends bit15 (zero if [2]=1); width 10 passes through.
  - Requests are ignored during DONE; next edge -> IDLE, where requests are resampled.
  - Non-owner's busy stays high if it is requesting.
- Latency from request seen in IDLE (cycle 0): store done at cycle N+1; load/fetch done at cycle N+2.
- Word load: 6 busy cycles, done in cycle 6.
- No preemption: a pending MA request waits for an in-progress fetch to finish.
- mem_wr=0 in IDLE, WAIT, DONE. mem_a holds its last value outside XFER.
- rdy=0: all registers hold, including mem outputs. The combinational busy outputs are unchanged in value.
- Reset mid-transfer aborts immediately: mem_wr drops asynchronously, no done is signalled.

Optional Feature:
- Macro: MEM_CTRL_IFBUF_EN.
- Defined: single-entry fetch buffer holding tag addr[31:2], valid bit and data.
  - if_re in IDLE with valid and tag match: no memory access; if_busy=1 only in cycle 0, DONE in cycle 1, if_rdata = buffered word.
  - A miss fills the buffer on completion.
  - Any MA store completion clears valid; reset clears valid.
  - MA request still wins arbitration over a hit.
- Undefined: no buffer; every fetch takes the full 6 cycles.

Test Plan:
- Load word, ram_re=1, ram_addr=0x100, width=010, mem bytes 0x100..0x103 = 78,56,34,12 -> mem_a 0x100..0x103 in cycles 1-4; ram_busy high cycles 0-5; ram_rdata=0x12345678 in cycle 6.
- Load byte 0x80 with width=000 -> ram_rdata=0xFFFFFF80. Same byte with width=100 -> 0x00000080. Half 0x8001 with width=001 -> 0xFFFF8001.
- Store half, ram_we=1, addr=0x203, wdata=0xAABBCCDD, width=001 -> mem_wr=1 in cycles 1-2 with (0x203,DD) then (0x204,CC); done in cycle 3; mem_wr=0 afterwards.
- if_re and ram_re asserted together in IDLE -> MA is served first with if_busy held high. Fetch starts the cycle after MA's DONE and completes 6 cycles after that.
- Reset mid-operation: rst=0 during XFER of a word store after the 2nd byte -> mem_wr=0 immediately, state IDLE, no further writes. After release, a new request completes normally.
- Fetch buffer (MEM_CTRL_IFBUF_EN): two fetches of 0x0 -> first takes 6 cycles, second done in cycle 1 with equal data. After an intervening store, the next fetch of 0x0 takes 6 cycles again.
- rdy=0 for 3 cycles during a load's XFER -> outputs frozen; result correct and done delayed by exactly 3 cycles.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: groups the MA request, IF request and byte-wide memory bus signals.
// Latency: none, wiring only.
// Backpressure: carries ram_busy/if_busy from the controller back to the requesters.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_addr;
  logic [2:0]        ram_width;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_busy;
  logic              if_re;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_busy;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  // Requesters plus memory: drive requests and read data, observe results and bus.
  modport master (
    output ram_we, ram_re, ram_addr, ram_width, ram_wdata,
    input  ram_rdata, ram_busy,
    output if_re, if_addr,
    input  if_rdata, if_busy,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );

  // Controller side.
  modport slave (
    input  ram_we, ram_re, ram_addr, ram_width, ram_wdata,
    output ram_rdata, ram_busy,
    input  if_re, if_addr,
    output if_rdata, if_busy,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes MA loads/stores and IF fetches into byte transfers on an 8-bit RAM bus.
// Latency: store N+1 cycles, load/fetch N+2 cycles from the request seen in IDLE (N = 1/2/4).
// Backpressure: ram_busy/if_busy stall the requesters; rdy=0 freezes all state.
// Optional: define MEM_CTRL_IFBUF_EN for a single-entry fetch buffer.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_MA, OWN_IF} owner_t;

  state_t      state;
  owner_t      owner;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [1:0]  cnt_p1;
  logic [1:0]  cnt_m1;
  logic        is_store;
  logic        zext;
  logic [1:0]  wsel;
  logic [31:0] wdata_q;
  logic [31:0] acc;
  logic [31:0] assembled;
  logic [31:0] extended;
  logic        ma_req;
  logic        buf_hit;

`ifdef MEM_CTRL_IFBUF_EN
  logic        buf_vld;
  logic [29:0] buf_tag;
  logic [31:0] buf_dat;
  logic [29:0] fill_tag;
  assign buf_hit = buf_vld && (buf_tag == bus.if_addr[31:2]);
`else
  assign buf_hit = 1'b0;
`endif

  assign ma_req = bus.ram_re | bus.ram_we;
  assign cnt_p1 = cnt + 2'd1;
  assign cnt_m1 = cnt - 2'd1;

  // Final read word: previously captured bytes plus the last byte arriving now.
  always_comb begin
    assembled = acc;
    assembled[{last, 3'b000} +: 8] = bus.mem_din;
  end

  // Load extension by access width; word passes through untouched.
  always_comb begin
    case (wsel)
      2'b00:   extended = zext ? {24'b0, assembled[7:0]}
                               : {{24{assembled[7]}}, assembled[7:0]};
      2'b01:   extended = zext ? {16'b0, assembled[15:0]}
                               : {{16{assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  // Stall outputs: owner stays busy until DONE, a waiting non-owner stays busy.
  always_comb begin
    bus.ram_busy = 1'b0;
    bus.if_busy  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          bus.ram_busy = ma_req;
          bus.if_busy  = bus.if_re;
        end
        XFER, WAIT: begin
          bus.ram_busy = (owner == OWN_MA) | ma_req;
          bus.if_busy  = (owner == OWN_IF) | bus.if_re;
        end
        default: begin
          bus.ram_busy = (owner == OWN_MA) ? 1'b0 : ma_req;
          bus.if_busy  = (owner == OWN_IF) ? 1'b0 : bus.if_re;
        end
      endcase
    end
  end

  // Transfer FSM with registered bus outputs and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      cnt           <= 2'd0;
      last          <= 2'd0;
      is_store      <= 1'b0;
      zext          <= 1'b0;
      wsel          <= 2'b00;
      wdata_q       <= 32'b0;
      acc           <= 32'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_a     <= '0;
      bus.mem_dout  <= 8'b0;
      bus.ram_rdata <= 32'b0;
      bus.if_rdata  <= 32'b0;
`ifdef MEM_CTRL_IFBUF_EN
      buf_vld       <= 1'b0;
      buf_tag       <= 30'b0;
      buf_dat       <= 32'b0;
      fill_tag      <= 30'b0;
`endif
    end else if (rdy) begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (ma_req) begin
            // A simultaneous load and store is handled as a store.
            owner        <= OWN_MA;
            is_store     <= bus.ram_we;
            wsel         <= bus.ram_width[1:0];
            zext         <= bus.ram_width[2];
            last         <= (bus.ram_width[1:0] == 2'b00) ? 2'd0 :
                            (bus.ram_width[1:0] == 2'b01) ? 2'd1 : 2'd3;
            wdata_q      <= bus.ram_wdata;
            bus.mem_a    <= bus.ram_addr[ADDR_W-1:0];
            bus.mem_wr   <= bus.ram_we;
            bus.mem_dout <= bus.ram_wdata[7:0];
            state        <= XFER;
          end else if (bus.if_re) begin
            owner    <= OWN_IF;
            is_store <= 1'b0;
            wsel     <= 2'b10;
            zext     <= 1'b0;
            last     <= 2'd3;
            if (buf_hit) begin
`ifdef MEM_CTRL_IFBUF_EN
              bus.if_rdata <= buf_dat;
`endif
              state <= DONE;
            end else begin
`ifdef MEM_CTRL_IFBUF_EN
              fill_tag <= bus.if_addr[31:2];
`endif
              bus.mem_a  <= bus.if_addr[ADDR_W-1:0];
              bus.mem_wr <= 1'b0;
              state      <= XFER;
            end
          end
        end
        XFER: begin
          // Read data lags the address by one cycle, so byte cnt-1 lands now.
          if (!is_store && cnt != 2'd0) begin
            acc[{cnt_m1, 3'b000} +: 8] <= bus.mem_din;
          end
          if (cnt == last) begin
            bus.mem_wr <= 1'b0;
            state      <= is_store ? DONE : WAIT;
`ifdef MEM_CTRL_IFBUF_EN
            if (is_store) buf_vld <= 1'b0;
`endif
          end else begin
            cnt       <= cnt_p1;
            bus.mem_a <= bus.mem_a + ADDR_W'(1);
            if (is_store) bus.mem_dout <= wdata_q[{cnt_p1, 3'b000} +: 8];
          end
        end
        WAIT: begin
          if (owner == OWN_MA) begin
            bus.ram_rdata <= extended;
          end else begin
            bus.if_rdata <= extended;
`ifdef MEM_CTRL_IFBUF_EN
            buf_vld <= 1'b1;
            buf_tag <= fill_tag;
            buf_dat <= extended;
`endif
          end
          state <= DONE;
        end
        default: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios for mem_ctrl against a byte-wide synchronous memory model.
// Latency: memory returns mem_din one enabled cycle after mem_a.
// Backpressure: requests are held until the matching busy drops.
module tb_mem_ctrl;
  logic clk;
  logic rst;
  logic rdy;
  int   passed;
  int   total;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: preload image plus bytes written by the controller.
  bit [7:0] init_mem [0:1023];
  bit [7:0] wr_mem   [0:1023];
  bit       wr_flag  [0:1023];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return wr_flag[a[9:0]] ? wr_mem[a[9:0]] : init_mem[a[9:0]];
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) begin
        wr_mem[bus.mem_a[9:0]]  <= bus.mem_dout;
        wr_flag[bus.mem_a[9:0]] <= 1'b1;
      end
      bus.mem_din <= mem_rd(bus.mem_a);
    end
  end

  // Drives an MA request at a falling edge and waits for its DONE cycle.
  task automatic ma_op(input logic we, input logic re, input logic [31:0] addr,
                       input logic [2:0] w, input logic [31:0] wd,
                       output int cyc, output logic [31:0] rd);
    bus.ram_we = we; bus.ram_re = re; bus.ram_addr = addr;
    bus.ram_width = w; bus.ram_wdata = wd;
    #1;
    cyc = 0;
    while (bus.ram_busy && cyc < 40) begin @(negedge clk); #1; cyc++; end
    rd = bus.ram_rdata;
    bus.ram_we = 1'b0; bus.ram_re = 1'b0;
    @(negedge clk);
  endtask

  // Drives a fetch at a falling edge and waits for its DONE cycle.
  task automatic if_op(input logic [31:0] addr, output int cyc, output logic [31:0] rd);
    bus.if_re = 1'b1; bus.if_addr = addr;
    #1;
    cyc = 0;
    while (bus.if_busy && cyc < 40) begin @(negedge clk); #1; cyc++; end
    rd = bus.if_rdata;
    bus.if_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ram_re = 1'b1; bus.if_re = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.mem_wr !== 1'b0) $display("FAIL reset mem_wr got %b exp 0", bus.mem_wr); else passed++;
    total++; if (bus.mem_a !== 32'h0) $display("FAIL reset mem_a got %h exp 0", bus.mem_a); else passed++;
    total++; if (bus.mem_dout !== 8'h0) $display("FAIL reset mem_dout got %h exp 0", bus.mem_dout); else passed++;
    total++; if (bus.ram_rdata !== 32'h0) $display("FAIL reset ram_rdata got %h exp 0", bus.ram_rdata); else passed++;
    total++; if (bus.if_rdata !== 32'h0) $display("FAIL reset if_rdata got %h exp 0", bus.if_rdata); else passed++;
    total++; if (bus.ram_busy !== 1'b0) $display("FAIL reset ram_busy got %b exp 0", bus.ram_busy); else passed++;
    total++; if (bus.if_busy !== 1'b0) $display("FAIL reset if_busy got %b exp 0", bus.if_busy); else passed++;
    bus.ram_re = 1'b0; bus.if_re = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    logic [31:0] ea;
    bus.ram_re = 1'b1; bus.ram_addr = 32'h100; bus.ram_width = 3'b010;
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      total++;
      if (bus.ram_busy !== 1'(c <= 5))
        $display("FAIL load_word busy c=%0d got %b exp %b", c, bus.ram_busy, c <= 5);
      else passed++;
      if (c >= 1 && c <= 4) begin
        ea = 32'h100 + 32'(c) - 32'd1;
        total++;
        if (bus.mem_a !== ea || bus.mem_wr !== 1'b0)
          $display("FAIL load_word addr c=%0d got %h/%b exp %h/0", c, bus.mem_a, bus.mem_wr, ea);
        else passed++;
      end
    end
    total++;
    if (bus.ram_rdata !== 32'h12345678) $display("FAIL load_word data got %h exp 12345678", bus.ram_rdata);
    else passed++;
    bus.ram_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_ext();
    int cyc; logic [31:0] rd;
    ma_op(1'b0, 1'b1, 32'h110, 3'b000, 32'h0, cyc, rd);
    total++; if (cyc != 3 || rd !== 32'hFFFFFF80) $display("FAIL ext_byte_s got %0d/%h exp 3/ffffff80", cyc, rd); else passed++;
    ma_op(1'b0, 1'b1, 32'h110, 3'b100, 32'h0, cyc, rd);
    total++; if (cyc != 3 || rd !== 32'h00000080) $display("FAIL ext_byte_z got %0d/%h exp 3/00000080", cyc, rd); else passed++;
    ma_op(1'b0, 1'b1, 32'h120, 3'b001, 32'h0, cyc, rd);
    total++; if (cyc != 4 || rd !== 32'hFFFF8001) $display("FAIL ext_half_s got %0d/%h exp 4/ffff8001", cyc, rd); else passed++;
    ma_op(1'b0, 1'b1, 32'h120, 3'b101, 32'h0, cyc, rd);
    total++; if (cyc != 4 || rd !== 32'h00008001) $display("FAIL ext_half_z got %0d/%h exp 4/00008001", cyc, rd); else passed++;
    ma_op(1'b0, 1'b1, 32'hFFFFFFFF, 3'b010, 32'h0, cyc, rd);
    total++; if (cyc != 6 || rd !== 32'h44332211) $display("FAIL wrap_word got %0d/%h exp 6/44332211", cyc, rd); else passed++;
  endtask

  task automatic test_store_half();
    int cyc; logic [31:0] rd;
    bus.ram_we = 1'b1; bus.ram_addr = 32'h203; bus.ram_width = 3'b001; bus.ram_wdata = 32'hAABBCCDD;
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c == 1) begin
        total++;
        if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h203 || bus.mem_dout !== 8'hDD)
          $display("FAIL store_b0 got %b/%h/%h exp 1/203/dd", bus.mem_wr, bus.mem_a, bus.mem_dout);
        else passed++;
      end
      if (c == 2) begin
        total++;
        if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h204 || bus.mem_dout !== 8'hCC)
          $display("FAIL store_b1 got %b/%h/%h exp 1/204/cc", bus.mem_wr, bus.mem_a, bus.mem_dout);
        else passed++;
      end
      if (c == 3) begin
        total++;
        if (bus.ram_busy !== 1'b0 || bus.mem_wr !== 1'b0)
          $display("FAIL store_done got busy %b wr %b exp 0/0", bus.ram_busy, bus.mem_wr);
        else passed++;
        bus.ram_we = 1'b0;
      end
      if (c == 4) begin
        total++;
        if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h204)
          $display("FAIL store_after got %b/%h exp 0/204", bus.mem_wr, bus.mem_a);
        else passed++;
      end
    end
    @(negedge clk);
    total++;
    if (mem_rd(32'h203) !== 8'hDD || mem_rd(32'h204) !== 8'hCC || mem_rd(32'h205) !== 8'h00)
      $display("FAIL store_mem got %h %h %h exp dd cc 00", mem_rd(32'h203), mem_rd(32'h204), mem_rd(32'h205));
    else passed++;
    // Both strobes high behaves as a one-byte store.
    ma_op(1'b1, 1'b1, 32'h384, 3'b000, 32'h0000005A, cyc, rd);
    total++;
    if (cyc != 2 || mem_rd(32'h384) !== 8'h5A)
      $display("FAIL we_re_store got %0d/%h exp 2/5a", cyc, mem_rd(32'h384));
    else passed++;
  endtask

  task automatic test_arbitration();
    bus.ram_re = 1'b1; bus.ram_addr = 32'h100; bus.ram_width = 3'b010;
    bus.if_re = 1'b1; bus.if_addr = 32'h0;
    #1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      total++;
      if (bus.ram_busy !== 1'(c < 6)) $display("FAIL arb ram_busy c=%0d got %b exp %b", c, bus.ram_busy, c < 6);
      else passed++;
      total++;
      if (bus.if_busy !== 1'(c < 13)) $display("FAIL arb if_busy c=%0d got %b exp %b", c, bus.if_busy, c < 13);
      else passed++;
      if (c == 6) begin
        total++;
        if (bus.ram_rdata !== 32'h12345678) $display("FAIL arb ram_rdata got %h exp 12345678", bus.ram_rdata);
        else passed++;
        bus.ram_re = 1'b0;
      end
      if (c == 8) begin
        total++;
        if (bus.mem_a !== 32'h0) $display("FAIL arb fetch_a0 got %h exp 0", bus.mem_a); else passed++;
      end
      if (c == 11) begin
        total++;
        if (bus.mem_a !== 32'h3) $display("FAIL arb fetch_a3 got %h exp 3", bus.mem_a); else passed++;
      end
      if (c == 13) begin
        total++;
        if (bus.if_rdata !== 32'h55443322) $display("FAIL arb if_rdata got %h exp 55443322", bus.if_rdata);
        else passed++;
        bus.if_re = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_buf();
    int cyc; int hit_cyc; logic [31:0] rd; logic [31:0] rd2;
`ifdef MEM_CTRL_IFBUF_EN
    hit_cyc = 1;
`else
    hit_cyc = 6;
`endif
    ma_op(1'b1, 1'b0, 32'h388, 3'b000, 32'h00000011, cyc, rd);
    if_op(32'h0, cyc, rd);
    total++; if (cyc != 6 || rd !== 32'h55443322) $display("FAIL fetch_first got %0d/%h exp 6/55443322", cyc, rd); else passed++;
    if_op(32'h0, cyc, rd2);
    total++; if (cyc != hit_cyc || rd2 !== 32'h55443322) $display("FAIL fetch_second got %0d/%h exp %0d/55443322", cyc, rd2, hit_cyc); else passed++;
    ma_op(1'b1, 1'b0, 32'h38C, 3'b000, 32'h00000022, cyc, rd);
    if_op(32'h0, cyc, rd);
    total++; if (cyc != 6 || rd !== 32'h55443322) $display("FAIL fetch_after_store got %0d/%h exp 6/55443322", cyc, rd); else passed++;
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] ea;
    bus.ram_re = 1'b1; bus.ram_addr = 32'h100; bus.ram_width = 3'b010;
    #1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c >= 1 && c <= 7) begin
        ea = (c <= 1) ? 32'h100 : (c <= 5) ? 32'h101 : 32'h100 + 32'(c) - 32'd4;
        total++;
        if (bus.mem_a !== ea || bus.mem_wr !== 1'b0)
          $display("FAIL rdy addr c=%0d got %h/%b exp %h/0", c, bus.mem_a, bus.mem_wr, ea);
        else passed++;
      end
      total++;
      if (bus.ram_busy !== 1'(c <= 8)) $display("FAIL rdy busy c=%0d got %b exp %b", c, bus.ram_busy, c <= 8);
      else passed++;
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
    end
    total++;
    if (bus.ram_rdata !== 32'h12345678) $display("FAIL rdy data got %h exp 12345678", bus.ram_rdata); else passed++;
    bus.ram_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] rd;
    bus.ram_we = 1'b1; bus.ram_addr = 32'h300; bus.ram_width = 3'b010; bus.ram_wdata = 32'h44332211;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h302 || bus.mem_dout !== 8'h33)
      $display("FAIL rstmid pre got %b/%h/%h exp 1/302/33", bus.mem_wr, bus.mem_a, bus.mem_dout);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0 || bus.ram_busy !== 1'b0)
      $display("FAIL rstmid abort got %b/%h/%b exp 0/0/0", bus.mem_wr, bus.mem_a, bus.ram_busy);
    else passed++;
    bus.ram_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_rd(32'h300) !== 8'h11 || mem_rd(32'h301) !== 8'h22 || mem_rd(32'h302) !== 8'hEE)
      $display("FAIL rstmid mem got %h %h %h exp 11 22 ee", mem_rd(32'h300), mem_rd(32'h301), mem_rd(32'h302));
    else passed++;
    ma_op(1'b0, 1'b1, 32'h300, 3'b010, 32'h0, cyc, rd);
    total++; if (cyc != 6 || rd !== 32'hFFEE2211) $display("FAIL rstmid reload got %0d/%h exp 6/ffee2211", cyc, rd); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0; total = 0;
    rst = 1'b0; rdy = 1'b1;
    bus.ram_we = 1'b0; bus.ram_re = 1'b0; bus.ram_addr = 32'h0;
    bus.ram_width = 3'b010; bus.ram_wdata = 32'h0;
    bus.if_re = 1'b0; bus.if_addr = 32'h0;
    bus.mem_din = 8'h0;
    init_mem[10'h100] = 8'h78; init_mem[10'h101] = 8'h56;
    init_mem[10'h102] = 8'h34; init_mem[10'h103] = 8'h12;
    init_mem[10'h110] = 8'h80;
    init_mem[10'h120] = 8'h01; init_mem[10'h121] = 8'h80;
    init_mem[10'h3FF] = 8'h11; init_mem[10'h000] = 8'h22;
    init_mem[10'h001] = 8'h33; init_mem[10'h002] = 8'h44; init_mem[10'h003] = 8'h55;
    init_mem[10'h302] = 8'hEE; init_mem[10'h303] = 8'hFF;

    test_reset();
    test_load_word();
    test_load_ext();
    test_store_half();
    test_arbitration();
    test_fetch_buf();
    test_rdy_freeze();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
